// File: rtl/cov_product_feeder_pkg.sv
// rtl/cov_product_feeder_pkg.sv - shared constants, state enum and product helper for the whitening covariance front end
package cov_product_feeder_pkg;

    localparam int N_SAMP = 128;
    localparam int LOG2_N = 7;
    localparam int DW     = 16;
    localparam int PW     = 52;
    localparam int SW     = DW + LOG2_N;
    localparam int LW     = 4 * DW;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MEAN,
        STREAM,
        TAIL,
        GAP
    } state_t;

    // Full-precision product of two centered samples, sign-extended to the output width
    function automatic logic signed [PW-1:0] cprod(input logic signed [DW:0] a,
                                                   input logic signed [DW:0] b);
        logic signed [2*DW+1:0] m;
        m = (2*DW+2)'(a) * (2*DW+2)'(b);
        return PW'(m);
    endfunction

endpackage

// File: rtl/cov_sample_buffer.sv
// rtl/cov_sample_buffer.sv - 4-lane sample store, one write port and one registered read port
module cov_sample_buffer
    import cov_product_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [LOG2_N-1:0] i_waddr,
    input  logic [LW-1:0]     i_wdata,
    input  logic              i_re,
    input  logic [LOG2_N-1:0] i_raddr,
    output logic [LW-1:0]     o_rdata
);

    logic [LW-1:0] r_mem [N_SAMP];

    // No reset on the array or read register so the storage maps onto block RAM
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/cov_product_feeder.sv
// rtl/cov_product_feeder.sv - block capture, per-channel means and centered cross-product streaming
module cov_product_feeder
    import cov_product_feeder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] x1,
    input  logic signed [DW-1:0] x2,
    input  logic signed [DW-1:0] x3,
    input  logic signed [DW-1:0] x4,
    output logic                 cov_en,
    output logic signed [PW-1:0] p11,
    output logic signed [PW-1:0] p12,
    output logic signed [PW-1:0] p13,
    output logic signed [PW-1:0] p14,
    output logic signed [PW-1:0] p22,
    output logic signed [PW-1:0] p23,
    output logic signed [PW-1:0] p24,
    output logic signed [PW-1:0] p33,
    output logic signed [PW-1:0] p34,
    output logic signed [PW-1:0] p44,
    output logic                 busy,
    output logic                 done
);

    localparam logic [LOG2_N:0] CNT_ONE  = (LOG2_N+1)'(1);
    localparam logic [LOG2_N:0] CNT_LAST = (LOG2_N+1)'(N_SAMP - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [LOG2_N:0]        r_cnt;
    logic signed [SW-1:0]   r_sum  [4];
    logic signed [DW-1:0]   r_mean [4];
    logic                   r_rd_valid;
    logic                   r_p_valid;
    logic signed [PW-1:0]   r_p    [10];

    logic signed [DW-1:0]   w_x    [4];
    logic signed [DW-1:0]   w_rd   [4];
    logic signed [DW:0]     w_c    [4];
    logic [LW-1:0]          w_rdata;
    logic                   w_accept;
    logic                   w_re;
    logic [LOG2_N-1:0]      w_waddr;
    logic [LOG2_N-1:0]      w_raddr;

    assign w_x[0] = x1;
    assign w_x[1] = x2;
    assign w_x[2] = x3;
    assign w_x[3] = x4;

    // s_ready is forced low while reset is held, then follows the capture states
    assign s_ready  = ((r_state == IDLE) || (r_state == LOAD)) && !rst;
    assign w_accept = s_valid && s_ready;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == GAP);
    // Window covers every valid product plus the zero-product dump cycle
    assign cov_en   = r_p_valid || (r_state == TAIL);

    // The first sample of a block always lands at address 0; later ones at the running count
    assign w_waddr = (r_state == IDLE) ? '0 : r_cnt[LOG2_N-1:0];
    assign w_re    = (r_state == MEAN) || ((r_state == STREAM) && !r_cnt[LOG2_N]);
    assign w_raddr = (r_state == MEAN) ? '0 : r_cnt[LOG2_N-1:0];

    cov_sample_buffer u_buf (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_waddr),
        .i_wdata ({x4, x3, x2, x1}),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Center each lane of the read data against its block mean
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_rd[k] = w_rdata[k*DW +: DW];
            w_c[k]  = (DW+1)'(w_rd[k]) - (DW+1)'(r_mean[k]);
        end
    end

    // Next-state sequencing of the block
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = LOAD;
            LOAD:    if (w_accept && (r_cnt == CNT_LAST)) w_next = MEAN;
            MEAN:    w_next = STREAM;
            STREAM:  if (r_p_valid && !r_rd_valid) w_next = TAIL;
            TAIL:    w_next = GAP;
            GAP:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Counter, channel sums, means and read-pipeline valid flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_p_valid  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_sum[k]  <= '0;
                r_mean[k] <= '0;
            end
        end else begin
            r_rd_valid <= w_re;
            r_p_valid  <= r_rd_valid;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt <= CNT_ONE;
                        for (int k = 0; k < 4; k++) r_sum[k] <= SW'(w_x[k]);
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_ONE;
                        for (int k = 0; k < 4; k++) r_sum[k] <= r_sum[k] + SW'(w_x[k]);
                    end
                end
                MEAN: begin
                    // Dropping the low LOG2_N bits is the flooring arithmetic shift
                    r_cnt <= CNT_ONE;
                    for (int k = 0; k < 4; k++) r_mean[k] <= r_sum[k][SW-1:LOG2_N];
                end
                STREAM: begin
                    if (!r_cnt[LOG2_N]) r_cnt <= r_cnt + CNT_ONE;
                end
                GAP: begin
                    r_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Product register: live products while read data is valid, zero otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 10; n++) r_p[n] <= '0;
        end else if (r_rd_valid) begin
            r_p[0] <= cprod(w_c[0], w_c[0]);
            r_p[1] <= cprod(w_c[0], w_c[1]);
            r_p[2] <= cprod(w_c[0], w_c[2]);
            r_p[3] <= cprod(w_c[0], w_c[3]);
            r_p[4] <= cprod(w_c[1], w_c[1]);
            r_p[5] <= cprod(w_c[1], w_c[2]);
            r_p[6] <= cprod(w_c[1], w_c[3]);
            r_p[7] <= cprod(w_c[2], w_c[2]);
            r_p[8] <= cprod(w_c[2], w_c[3]);
            r_p[9] <= cprod(w_c[3], w_c[3]);
        end else begin
            for (int n = 0; n < 10; n++) r_p[n] <= '0;
        end
    end

    assign p11 = r_p[0];
    assign p12 = r_p[1];
    assign p13 = r_p[2];
    assign p14 = r_p[3];
    assign p22 = r_p[4];
    assign p23 = r_p[5];
    assign p24 = r_p[6];
    assign p33 = r_p[7];
    assign p34 = r_p[8];
    assign p44 = r_p[9];

endmodule

// File: tb/tb_cov_product_feeder.sv
// tb/tb_cov_product_feeder.sv - self-checking bench for cov_product_feeder
module tb_cov_product_feeder;
    import cov_product_feeder_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] x1, x2, x3, x4;
    logic                 cov_en;
    logic signed [PW-1:0] p11, p12, p13, p14, p22, p23, p24, p33, p34, p44;
    logic                 busy;
    logic                 done;

    int     checks;
    int     errors;
    int     smp [N_SAMP][4];
    int     pi  [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    int     pj  [10] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
    longint first_p11, first_p12, last_p11;

    cov_product_feeder dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .cov_en(cov_en),
        .p11(p11), .p12(p12), .p13(p13), .p14(p14), .p22(p22),
        .p23(p23), .p24(p24), .p33(p33), .p34(p34), .p44(p44),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic longint dut_p(input int n);
        case (n)
            0: return longint'(p11);
            1: return longint'(p12);
            2: return longint'(p13);
            3: return longint'(p14);
            4: return longint'(p22);
            5: return longint'(p23);
            6: return longint'(p24);
            7: return longint'(p33);
            8: return longint'(p34);
            default: return longint'(p44);
        endcase
    endfunction

    // Mean is the floor of the block average, computed with plain integer arithmetic
    function automatic int floor_mean(input int ch);
        int s, m;
        s = 0;
        for (int i = 0; i < N_SAMP; i++) s += smp[i][ch];
        m = s / N_SAMP;
        if ((s % N_SAMP != 0) && (s < 0)) m = m - 1;
        return m;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N_SAMP; i++)
            for (int k = 0; k < 4; k++)
                smp[i][k] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    // mode 0: valid every cycle, 1: one cycle in three, 2: random gaps
    task automatic drive_block(input int mode, output int first_acc, output int cycles);
        int idx;
        bit v;
        idx = 0;
        cycles = 0;
        first_acc = -1;
        while (idx < N_SAMP && cycles < 4000) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cycles % 3 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            s_valid = v;
            x1 = DW'(smp[idx][0]);
            x2 = DW'(smp[idx][1]);
            x3 = DW'(smp[idx][2]);
            x4 = DW'(smp[idx][3]);
            if (v && s_ready) begin
                if (first_acc < 0) first_acc = cycles;
                idx++;
            end
            cycles++;
        end
        checks++;
        if (idx != N_SAMP) begin
            errors++;
            $display("FAIL load_timeout: accepted=%0d required=%0d", idx, N_SAMP);
        end
    endtask

    // Walks the cycles after the last accept; abort_at>0 pulses reset at that cycle instead
    task automatic check_window(input bit hold, input int abort_at);
        int     mean [4];
        longint exp_p;
        bit     exp_en;
        for (int k = 0; k < 4; k++) mean[k] = floor_mean(k);
        for (int c = 1; c <= 132; c++) begin
            @(negedge clk);
            s_valid = hold;
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                checks++;
                if (cov_en !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid_ctrl: cov_en=%b busy=%b s_ready=%b required=0 0 0", cov_en, busy, s_ready);
                end
                for (int n = 0; n < 10; n++) begin
                    checks++;
                    if (dut_p(n) !== 0) begin
                        errors++;
                        $display("FAIL reset_mid_p%0d: got=%0d required=0", n, dut_p(n));
                    end
                end
                return;
            end
            exp_en = (c >= 3) && (c <= 131);
            checks++;
            if (cov_en !== exp_en) begin
                errors++;
                $display("FAIL cov_en c=%0d: got=%b required=%b", c, cov_en, exp_en);
            end
            checks++;
            if (s_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ready_busy c=%0d: s_ready=%b busy=%b required=0 1", c, s_ready, busy);
            end
            checks++;
            if (done !== (c == 132)) begin
                errors++;
                $display("FAIL done c=%0d: got=%b required=%b", c, done, (c == 132));
            end
            for (int n = 0; n < 10; n++) begin
                if (c >= 3 && c <= 130)
                    exp_p = longint'(smp[c-3][pi[n]] - mean[pi[n]]) * longint'(smp[c-3][pj[n]] - mean[pj[n]]);
                else
                    exp_p = 0;
                checks++;
                if (dut_p(n) !== exp_p) begin
                    errors++;
                    $display("FAIL product p%0d c=%0d: got=%0d required=%0d", n, c, dut_p(n), exp_p);
                end
            end
            if (c == 3) begin
                first_p11 = dut_p(0);
                first_p12 = dut_p(1);
            end
            if (c == 130) last_p11 = dut_p(0);
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || cov_en !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b s_ready=%b cov_en=%b required=0 1 0", name, busy, s_ready, cov_en);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || cov_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: s_ready=%b cov_en=%b busy=%b done=%b required=0 0 0 0", s_ready, cov_en, busy, done);
        end
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (dut_p(n) !== 0) begin
                errors++;
                $display("FAIL reset_p%0d: got=%0d required=0", n, dut_p(n));
            end
        end
        rst = 1'b0;
        check_idle("reset_release");
    endtask

    task automatic test_constant();
        int fa, cy;
        for (int i = 0; i < N_SAMP; i++) for (int k = 0; k < 4; k++) smp[i][k] = 100;
        drive_block(0, fa, cy);
        check_window(1'b0, 0);
        checks++;
        if (first_p11 !== 0) begin
            errors++;
            $display("FAIL const_p11: got=%0d required=0", first_p11);
        end
        check_idle("const_idle");
    endtask

    task automatic test_alternating();
        int fa, cy;
        for (int i = 0; i < N_SAMP; i++) begin
            smp[i][0] = (i % 2 == 0) ? 1000 : -1000;
            smp[i][1] = -smp[i][0];
            smp[i][2] = 0;
            smp[i][3] = 0;
        end
        drive_block(0, fa, cy);
        check_window(1'b0, 0);
        checks++;
        if (first_p11 !== 64'sd1000000 || first_p12 !== -64'sd1000000) begin
            errors++;
            $display("FAIL alt_values: p11=%0d p12=%0d required=1000000 -1000000", first_p11, first_p12);
        end
        check_idle("alt_idle");
    endtask

    task automatic test_extreme();
        int fa, cy;
        for (int i = 0; i < N_SAMP; i++) begin
            smp[i][0] = (i < 64) ? -32768 : 32767;
            smp[i][1] = int'($urandom_range(0, 65535)) - 32768;
            smp[i][2] = -32768;
            smp[i][3] = 32767;
        end
        drive_block(0, fa, cy);
        check_window(1'b0, 0);
        checks++;
        if (first_p11 !== 64'sd1073676289) begin
            errors++;
            $display("FAIL extreme_first_p11: got=%0d required=1073676289", first_p11);
        end
        checks++;
        if (last_p11 !== 64'sd1073741824) begin
            errors++;
            $display("FAIL extreme_last_p11: got=%0d required=1073741824", last_p11);
        end
        check_idle("extreme_idle");
    endtask

    task automatic test_gaps();
        int fa, cy;
        fill_random();
        drive_block(1, fa, cy);
        checks++;
        if (cy != 3 * (N_SAMP - 1) + 1) begin
            errors++;
            $display("FAIL gaps_cycles: got=%0d required=%0d", cy, 3 * (N_SAMP - 1) + 1);
        end
        check_window(1'b0, 0);
        check_idle("gaps_idle");
    endtask

    task automatic test_reset_mid();
        int fa, cy;
        fill_random();
        drive_block(0, fa, cy);
        check_window(1'b0, 42);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_mid_idle");
        fill_random();
        drive_block(0, fa, cy);
        check_window(1'b0, 0);
        check_idle("reset_mid_after");
    endtask

    task automatic test_back_to_back();
        int fa, cy;
        fill_random();
        drive_block(0, fa, cy);
        check_window(1'b1, 0);
        fill_random();
        drive_block(0, fa, cy);
        checks++;
        if (fa != 0) begin
            errors++;
            $display("FAIL b2b_first_accept: wait=%0d required=0", fa);
        end
        check_window(1'b0, 0);
        check_idle("b2b_idle");
    endtask

    task automatic test_random();
        int fa, cy;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            drive_block(2, fa, cy);
            check_window(1'b0, 0);
        end
        check_idle("random_idle");
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        x1 = '0; x2 = '0; x3 = '0; x4 = '0;
        first_p11 = 0;
        first_p12 = 0;
        last_p11  = 0;
        test_reset();
        test_constant();
        test_alternating();
        test_extreme();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
